// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per cycle via a WIDTH+1-bit trial subtraction.
// Optional signed mode (port Signed) is compiled in when DIV32_SIGNED_EN is defined.
module div32_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef DIV32_SIGNED_EN
    input  logic             Signed,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r, q, b_reg;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_step, q_step;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             last_iter;

`ifdef DIV32_SIGNED_EN
    logic neg_q, neg_r;

    always_comb begin
        a_mag = (Signed && A[WIDTH-1]) ? -A : A;
        b_mag = (Signed && B[WIDTH-1]) ? -B : B;
        q_fin = neg_q ? -q_step : q_step;
        r_fin = neg_r ? -r_step : r_step;
    end
`else
    always_comb begin
        a_mag = A;
        b_mag = B;
        q_fin = q_step;
        r_fin = r_step;
    end
`endif

    // Borrow out of the trial subtraction (trial[WIDTH]) means the divisor did not fit.
    always_comb begin
        trial     = {r, q[WIDTH-1]} - {1'b0, b_reg};
        last_iter = (cnt == CNTW'(WIDTH - 1));
        if (!trial[WIDTH]) begin
            r_step = trial[WIDTH-1:0];
            q_step = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_step = {r[WIDTH-2:0], q[WIDTH-1]};
            q_step = {q[WIDTH-2:0], 1'b0};
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) state_nxt = (B == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                Busy = 1'b1;
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r         <= '0;
            q         <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
`ifdef DIV32_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        DivZero <= (B == '0);
                        if (B == '0) begin
                            Quotient  <= '1;
                            Remainder <= A;
                        end else begin
                            r     <= '0;
                            q     <= a_mag;
                            b_reg <= b_mag;
                            cnt   <= '0;
`ifdef DIV32_SIGNED_EN
                            neg_q <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r <= Signed & A[WIDTH-1];
`endif
                        end
                    end
                end
                S_RUN: begin
                    r   <= r_step;
                    q   <= q_step;
                    cnt <= cnt + CNTW'(1);
                    if (last_iter) begin
                        Quotient  <= q_fin;
                        Remainder <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq; signed cases build only with DIV32_SIGNED_EN.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [31:0] A, B;
    logic        Busy, Done, DivZero;
    logic [31:0] Quotient, Remainder;
`ifdef DIV32_SIGNED_EN
    logic        Signed = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div32_seq #(.WIDTH(32), .CNTW(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
`ifdef DIV32_SIGNED_EN
        .Signed    (Signed),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero)
    );

    // Drives one Start pulse, then waits (bounded) for Done; lat counts cycles after the accept edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat, output int busy_cnt);
        @(negedge clk);
        Start = 1'b1; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
        lat = 0; busy_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            if (Done) begin lat = i; break; end
            if (Busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] eq, input logic [31:0] er, input logic edz);
        n_cmp++;
        if (Quotient !== eq) begin n_err++; $display("FAIL %s quotient: got %h want %h", name, Quotient, eq); end
        n_cmp++;
        if (Remainder !== er) begin n_err++; $display("FAIL %s remainder: got %h want %h", name, Remainder, er); end
        n_cmp++;
        if (DivZero !== edz) begin n_err++; $display("FAIL %s divzero: got %b want %b", name, DivZero, edz); end
    endtask

    task automatic test_reset;
        reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({Busy, Done} !== 2'b00) begin n_err++; $display("FAIL reset busy/done: got %b want 00", {Busy, Done}); end
        check_result("reset", 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bc;
        do_op(32'd100, 32'd7, lat, bc);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL basic latency: got %0d want 33", lat); end
        n_cmp++;
        if (bc !== 32) begin n_err++; $display("FAIL basic busy cycles: got %0d want 32", bc); end
        check_result("basic", 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({Busy, Done} !== 2'b00) begin n_err++; $display("FAIL done pulse width: got %b want 00", {Busy, Done}); end
        n_cmp++;
        if (Quotient !== 32'd14) begin n_err++; $display("FAIL quotient hold: got %h want %h", Quotient, 32'd14); end
    endtask

    task automatic test_boundary;
        int lat, bc;
        do_op(32'hFFFF_FFFF, 32'd1, lat, bc);
        check_result("max_div_1", 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_op(32'd5, 32'hFFFF_FFFF, lat, bc);
        check_result("5_div_max", 32'h0, 32'd5, 1'b0);
    endtask

    task automatic test_divzero;
        int lat, bc;
        do_op(32'h1234, 32'h0, lat, bc);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL divzero latency: got %0d want 1", lat); end
        check_result("divzero", 32'hFFFF_FFFF, 32'h1234, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (DivZero !== 1'b1) begin n_err++; $display("FAIL divzero hold: got %b want 1", DivZero); end
        Start = 1'b1; A = 32'd9; B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        n_cmp++;
        if ({Busy, DivZero} !== 2'b10) begin n_err++; $display("FAIL divzero clear on start: got %b want 10", {Busy, DivZero}); end
        for (int i = 0; i < 60 && !Done; i++) @(negedge clk);
        check_result("after_divzero", 32'd3, 32'd0, 1'b0);
    endtask

    task automatic test_ignore;
        int ndone;
        @(negedge clk);
        Start = 1'b1; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        Start = 1'b1; A = 32'd9; B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 60 && !Done; i++) @(negedge clk);
        check_result("ignore_busy", 32'd14, 32'd2, 1'b0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin n_err++; $display("FAIL ignored start queued: got %0d active cycles want 0", ndone); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        Start = 1'b1; A = 32'd100; B = 32'd7;
        @(negedge clk);
        A = 32'd9; B = 32'd3;
        for (int i = 0; i < 60 && !Done; i++) @(negedge clk);
        check_result("b2b_first", 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({Busy, Done} !== 2'b00) begin n_err++; $display("FAIL b2b idle gap: got %b want 00", {Busy, Done}); end
        @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b1) begin n_err++; $display("FAIL b2b second accept: got busy %b want 1", Busy); end
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            if (Done) begin lat = i; break; end
            @(negedge clk);
        end
        Start = 1'b0;
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL b2b second latency: got %0d want 33", lat); end
        check_result("b2b_second", 32'd3, 32'd0, 1'b0);
    endtask

    task automatic test_reset_abort;
        int lat, bc, ndone;
        @(negedge clk);
        Start = 1'b1; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({Busy, Done} !== 2'b00) begin n_err++; $display("FAIL abort busy/done: got %b want 00", {Busy, Done}); end
        check_result("abort", 32'h0, 32'h0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin n_err++; $display("FAIL abort spurious done: got %0d want 0", ndone); end
        do_op(32'd9, 32'd3, lat, bc);
        check_result("after_abort", 32'd3, 32'd0, 1'b0);
    endtask

`ifdef DIV32_SIGNED_EN
    task automatic test_signed;
        int lat, bc;
        Signed = 1'b1;
        do_op(32'hFFFF_FFF9, 32'd2, lat, bc);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL signed latency: got %0d want 33", lat); end
        check_result("signed_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        check_result("signed_minneg", 32'h8000_0000, 32'h0, 1'b0);
        do_op(32'hFFFF_FFF9, 32'h0, lat, bc);
        check_result("signed_divzero", 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        Signed = 1'b0;
        do_op(32'hFFFF_FFF9, 32'd2, lat, bc);
        check_result("unsigned_mode", 32'h7FFF_FFFC, 32'd1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_divzero();
        test_ignore();
        test_back_to_back();
        test_reset_abort();
`ifdef DIV32_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
